// File: rtl/traffic_pkg.sv
// traffic_pkg: shared encodings and default durations for the traffic light timer.
package traffic_pkg;
  typedef enum logic {GREEN = 1'b0, YELLOW = 1'b1} phase_t;
  typedef enum logic {HWY = 1'b0, CTRY = 1'b1} owner_t;
  typedef enum logic [1:0] {IDLE = 2'b01, RUN = 2'b10} state_t;
  localparam logic [7:0] DEF_GREEN = 8'd30;
  localparam logic [7:0] DEF_YELLOW = 8'd4;
endpackage

// File: rtl/light_down_counter.sv
// light_down_counter: loadable down-counter with enable and zero flag.
module light_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= value;
    else if (en) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/shared_light_timer.sv
// shared_light_timer: one countdown timer shared round-robin between the
// highway and country-road controllers.
module shared_light_timer
  import traffic_pkg::*;
#(
  parameter int unsigned           TIMER_W  = 8,
  parameter logic [TIMER_W-1:0]    T_GREEN  = TIMER_W'(DEF_GREEN),
  parameter logic [TIMER_W-1:0]    T_YELLOW = TIMER_W'(DEF_YELLOW)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic start_h,
  input  logic phase_h,
  input  logic start_c,
  input  logic phase_c,
  output logic time_out_h,
  output logic time_out_c,
  output logic busy,
  output logic owner
);
  // A zero duration would underflow the load value, so it behaves as one tick.
  localparam logic [TIMER_W-1:0] G_EFF = (T_GREEN == '0) ? TIMER_W'(1) : T_GREEN;
  localparam logic [TIMER_W-1:0] Y_EFF = (T_YELLOW == '0) ? TIMER_W'(1) : T_YELLOW;
  state_t state;
  owner_t own;
  phase_t ph_h, ph_c;
  logic pend_h, pend_c, grant, gnt_c, zero;
  phase_t pick_ph;
  logic [TIMER_W-1:0] load_val;
  // On a tie the requester that did not hold the timer last wins.
  assign grant = state == IDLE && (pend_h || pend_c);
  assign gnt_c = pend_c && (!pend_h || own == HWY);
  assign pick_ph = gnt_c ? ph_c : ph_h;
  assign load_val = (pick_ph == YELLOW ? Y_EFF : G_EFF) - 1'b1;
  assign busy = state == RUN;
  assign owner = own;
  light_down_counter #(.W(TIMER_W)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .load(grant),
    .value(load_val),
    .en(state == RUN && tick && !zero),
    .zero(zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      own <= CTRY;
      pend_h <= 1'b0;
      pend_c <= 1'b0;
      ph_h <= GREEN;
      ph_c <= GREEN;
      time_out_h <= 1'b0;
      time_out_c <= 1'b0;
    end else begin
      time_out_h <= 1'b0;
      time_out_c <= 1'b0;
      pend_h <= start_h || (pend_h && !(grant && !gnt_c));
      pend_c <= start_c || (pend_c && !(grant && gnt_c));
      if (start_h) ph_h <= phase_t'(phase_h);
      if (start_c) ph_c <= phase_t'(phase_c);
      if (grant) begin
        state <= RUN;
        own <= gnt_c ? CTRY : HWY;
      end else if (state == RUN && tick && zero) begin
        state <= IDLE;
        time_out_h <= own == HWY;
        time_out_c <= own == CTRY;
      end
    end
endmodule

// File: tb/tb_shared_light_timer.sv
// tb_shared_light_timer: directed checks of the shared light timer with
// T_GREEN = 5 and T_YELLOW = 2.
module tb_shared_light_timer;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b1;
  logic start_h = 1'b0, phase_h = 1'b0, start_c = 1'b0, phase_c = 1'b0;
  logic time_out_h, time_out_c, busy, owner;
  int checks = 0, failures = 0;

  shared_light_timer #(.TIMER_W(8), .T_GREEN(8'd5), .T_YELLOW(8'd2)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .start_h(start_h), .phase_h(phase_h), .start_c(start_c), .phase_c(phase_c),
    .time_out_h(time_out_h), .time_out_c(time_out_c), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Highway green interval from idle: start sampled at edge 0, time_out_h after edge 6.
  task automatic run_hwy_green(input string tag);
    start_h = 1'b1; phase_h = 1'b0;
    @(negedge clk);
    start_h = 1'b0;
    chk({tag, "_busy_e0"}, busy, 0);
    @(negedge clk);
    chk({tag, "_busy_e1"}, busy, 1);
    chk({tag, "_owner_e1"}, owner, 0);
    for (int e = 2; e <= 5; e++) begin
      @(negedge clk);
      chk($sformatf("%s_to_h_e%0d", tag, e), time_out_h, 0);
    end
    @(negedge clk);
    chk({tag, "_to_h_e6"}, time_out_h, 1);
    chk({tag, "_to_c_e6"}, time_out_c, 0);
    chk({tag, "_busy_e6"}, busy, 0);
    @(negedge clk);
    chk({tag, "_to_h_e7"}, time_out_h, 0);
    chk({tag, "_owner_e7"}, owner, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_to_h", time_out_h, 0);
    chk("rst_to_c", time_out_c, 0);
    chk("rst_owner", owner, 1);
    rst_n = 1'b1;
    @(negedge clk);

    run_hwy_green("single");

    // Simultaneous requests after reset: highway first, then country.
    rst_n = 1'b0;
    #1;
    chk("rst2_owner", owner, 1);
    rst_n = 1'b1;
    @(negedge clk);
    start_h = 1'b1; phase_h = 1'b0; start_c = 1'b1; phase_c = 1'b0;
    @(negedge clk);
    start_h = 1'b0; start_c = 1'b0;
    @(negedge clk);
    chk("tie_owner_e1", owner, 0);
    repeat (5) @(negedge clk);
    chk("tie_to_h_e6", time_out_h, 1);
    chk("tie_to_c_e6", time_out_c, 0);
    @(negedge clk);
    chk("tie_busy_e7", busy, 1);
    chk("tie_owner_e7", owner, 1);
    chk("tie_to_h_e7", time_out_h, 0);
    for (int e = 8; e <= 11; e++) begin
      @(negedge clk);
      chk($sformatf("tie_to_c_e%0d", e), time_out_c, 0);
    end
    @(negedge clk);
    chk("tie_to_c_e12", time_out_c, 1);
    chk("tie_to_h_e12", time_out_h, 0);
    @(negedge clk);
    chk("tie_to_c_e13", time_out_c, 0);
    chk("tie_busy_e13", busy, 0);

    // Country yellow request arriving mid highway interval.
    start_h = 1'b1; phase_h = 1'b0;
    @(negedge clk);
    start_h = 1'b0;
    @(negedge clk);
    chk("mid_owner_e1", owner, 0);
    @(negedge clk);
    start_c = 1'b1; phase_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    chk("mid_owner_e3", owner, 0);
    repeat (2) @(negedge clk);
    chk("mid_to_h_e5", time_out_h, 0);
    @(negedge clk);
    chk("mid_to_h_e6", time_out_h, 1);
    @(negedge clk);
    chk("mid_owner_e7", owner, 1);
    chk("mid_busy_e7", busy, 1);
    @(negedge clk);
    chk("mid_to_c_e8", time_out_c, 0);
    @(negedge clk);
    chk("mid_to_c_e9", time_out_c, 1);
    @(negedge clk);
    chk("mid_to_c_e10", time_out_c, 0);
    chk("mid_busy_e10", busy, 0);

    // Sparse ticks: strobe on edges 1,4,7,...; expiry after the 6th strobe (edge 16).
    tick = 1'b0;
    start_c = 1'b1; phase_c = 1'b0;
    @(negedge clk);
    start_c = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      tick = (e % 3 == 1);
      @(negedge clk);
      chk($sformatf("sparse_to_c_e%0d", e), time_out_c, (e == 16));
      chk($sformatf("sparse_busy_e%0d", e), busy, (e <= 15));
    end
    tick = 1'b1;

    // Reset three edges into a run discards the interval.
    start_h = 1'b1; phase_h = 1'b0;
    @(negedge clk);
    start_h = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_to_h", time_out_h, 0);
    chk("arst_owner", owner, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      chk($sformatf("arst_quiet_h%0d", e), time_out_h, 0);
      chk($sformatf("arst_quiet_b%0d", e), busy, 0);
    end
    run_hwy_green("after_rst");

    // Two country starts while pending: latest phase (yellow) wins.
    start_h = 1'b1; phase_h = 1'b1;
    @(negedge clk);
    start_h = 1'b0;
    @(negedge clk);
    start_c = 1'b1; phase_c = 1'b0;
    @(negedge clk);
    phase_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    chk("rep_to_h_e3", time_out_h, 1);
    @(negedge clk);
    chk("rep_owner_e4", owner, 1);
    chk("rep_busy_e4", busy, 1);
    @(negedge clk);
    chk("rep_to_c_e5", time_out_c, 0);
    @(negedge clk);
    chk("rep_to_c_e6", time_out_c, 1);
    @(negedge clk);
    chk("rep_to_c_e7", time_out_c, 0);
    chk("rep_busy_e7", busy, 0);
    @(negedge clk);
    chk("rep_busy_e8", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shared_light_timer.md
SHARED_LIGHT_TIMER -- requirements
Module: shared_light_timer

Interface
REQ-001 Parameter TIMER_W, default 8, width of the countdown counter.
REQ-002 Parameter T_GREEN, default 8'd30, green-phase duration in ticks.
REQ-003 Parameter T_YELLOW, default 8'd4, yellow-phase duration in ticks.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 tick  input  1  one-cycle count-enable strobe from the seconds prescaler.
REQ-007 start_h  input  1  one-cycle timing request from the highway controller.
REQ-008 phase_h  input  1  highway requested phase: 0 = green, 1 = yellow.
REQ-009 start_c  input  1  one-cycle timing request from the country-road controller.
REQ-010 phase_c  input  1  country requested phase: 0 = green, 1 = yellow.
REQ-011 time_out_h  output  1  one-cycle expiry pulse to the highway controller.
REQ-012 time_out_c  output  1  one-cycle expiry pulse to the country-road controller.
REQ-013 busy  output  1  high while a timing interval is running.
REQ-014 owner  output  1  current or last grant holder: 0 = highway, 1 = country.

Function
REQ-015 One down-counter SHALL be shared between the two requesters; at most one interval runs at a time.
REQ-016 start_x high on a clock edge SHALL set pending_x and capture phase_x; a repeat start_x while pending_x is set SHALL overwrite the captured phase (latest wins).
REQ-017 FSM states SHALL be IDLE and RUN, one-hot encoded.
REQ-018 IDLE with no pending request: hold; busy = 0.
REQ-019 IDLE with pending request(s): on the next edge, grant one requester, clear its pending flag, set owner, load counter = duration - 1, and enter RUN.
REQ-020 Duration SHALL be T_GREEN for phase 0 and T_YELLOW for phase 1; a parameter value of 0 SHALL be treated as 1.
REQ-021 Both pending in IDLE: grant the requester that is not the last owner (round-robin).
REQ-022 RUN with tick = 1 and counter != 0: decrement the counter by 1; with tick = 0: hold.
REQ-023 RUN with tick = 1 and counter == 0: pulse time_out of the owner for exactly one cycle (registered), then return to IDLE.
REQ-024 A start from the current owner, or from the other requester, during RUN SHALL only set pending and SHALL NOT disturb the running interval.
REQ-025 time_out_h and time_out_c SHALL never be high in the same cycle.
REQ-026 Latency: with tick held high and the block idle, time_out_x SHALL be high in the cycle after the (D+1)th edge following the edge that sampled start_x, where D is the duration.
REQ-027 busy SHALL equal (state == RUN), registered.

Reset
REQ-028 Asserting rst_n low SHALL immediately force: state = IDLE, counter = 0, pending_h = pending_c = 0, time_out_h = time_out_c = 0, busy = 0.
REQ-029 Reset SHALL set owner = 1 (country), so the highway wins the first tie.
REQ-030 Reset asserted mid-interval SHALL discard the interval without any time_out pulse.

Structure
REQ-031 Package traffic_pkg SHALL hold the phase encoding (GREEN/YELLOW), the owner encoding (HWY/CTRY), the FSM state constants, and the default durations.
REQ-032 The loadable down-counter (load, value, enable, zero flag) SHALL be a sub-module named light_down_counter; arbitration and the FSM live in shared_light_timer.

Verification (T_GREEN = 5, T_YELLOW = 2, tick held high unless stated)
REQ-033 start_h (phase 0) at edge 0 -> busy high after edge 1; time_out_h high only in the cycle after edge 6; owner = 0.
REQ-034 start_h and start_c in the same cycle after reset -> highway served first; country granted on the edge after the highway's time_out_h; owner = 1.
REQ-035 start_c (phase 1) during a highway RUN -> highway interval unchanged; country interval of 2 ticks follows; time_out_c fires once.
REQ-036 tick strobed every 3rd cycle, start_c phase 0 -> time_out_c after 6 tick strobes; counter holds between strobes.
REQ-037 rst_n pulsed low 3 edges into a RUN -> outputs zero immediately; no time_out pulse; a later start_h behaves as in REQ-033.
REQ-038 Two start_c pulses while pending (phase 0, then phase 1) -> a single yellow interval of 2 ticks and one time_out_c.
